// File: rtl/usb_fs_in_arb.sv
// Round-robin arbiter sharing the IN protocol engine's endpoint write port among NUM_REQ clients.
// Optional idle-put watchdog enabled by defining USB_IN_ARB_TIMEOUT_EN.
module usb_fs_in_arb #(
    parameter int NUM_REQ        = 4,
    parameter int NUM_IN_EPS     = 11,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic [4*NUM_REQ-1:0]  req_ep_i,
    input  logic [NUM_REQ-1:0]    req_put_i,
    input  logic [8*NUM_REQ-1:0]  req_data_i,
    input  logic [NUM_REQ-1:0]    req_done_i,
    output logic [NUM_REQ-1:0]    grant_o,
    output logic [NUM_REQ-1:0]    req_free_o,
    output logic [NUM_REQ-1:0]    req_acked_o,
    output logic [NUM_IN_EPS-1:0] in_ep_data_put_o,
    output logic [7:0]            in_ep_data_o,
    output logic [NUM_IN_EPS-1:0] in_ep_data_done_o,
    input  logic [NUM_IN_EPS-1:0] in_ep_data_free_i,
    input  logic [NUM_IN_EPS-1:0] in_ep_acked_i
);

    localparam int RW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, XFER, RELEASE} state_e;

    state_e              state_q, state_d;
    logic [RW-1:0]       owner_q, owner_d;
    logic [RW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [3:0]          cur_ep_q, cur_ep_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;

    logic [15:0]         free_pad, acked_pad;
    logic [NUM_REQ-1:0]  eligible;
    logic [3:0]          ep_arr   [NUM_REQ];
    logic [7:0]          data_arr [NUM_REQ];
    logic                found;
    logic [RW-1:0]       pick, cand;
    logic                own_req, own_put, own_done, cur_free, put_ok, wd_fire;
    logic [7:0]          own_data;

    // Zero-padding makes out-of-range endpoint numbers read as not free and not acked.
    assign free_pad  = 16'(in_ep_data_free_i);
    assign acked_pad = 16'(in_ep_acked_i);

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_client
        assign ep_arr[g]      = req_ep_i[4*g +: 4];
        assign data_arr[g]    = req_data_i[8*g +: 8];
        assign eligible[g]    = req_i[g] && free_pad[ep_arr[g]];
        assign req_free_o[g]  = grant_q[g] && free_pad[ep_arr[g]];
        assign req_acked_o[g] = acked_pad[ep_arr[g]];
    end

    assign own_req  = req_i[owner_q];
    assign own_put  = req_put_i[owner_q];
    assign own_done = req_done_i[owner_q];
    assign own_data = data_arr[owner_q];
    assign cur_free = free_pad[cur_ep_q];
    assign put_ok   = (state_q == XFER) && own_put && cur_free;
    assign grant_o  = grant_q;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            cand = RW'((int'(rr_ptr_q) + j) % NUM_REQ);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

`ifdef USB_IN_ARB_TIMEOUT_EN
    logic [7:0] wd_q, wd_d;

    always_comb begin
        wd_d    = '0;
        wd_fire = 1'b0;
        if (state_q == XFER && !put_ok) begin
            wd_d    = wd_q + 8'd1;
            wd_fire = (wd_d == 8'(TIMEOUT_CYCLES));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) wd_q <= '0;
        else       wd_q <= wd_d;
    end
`else
    assign wd_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cur_ep_q <= '0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cur_ep_q <= cur_ep_d;
            grant_q  <= grant_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cur_ep_d = cur_ep_q;
        grant_d  = grant_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d       = XFER;
                    owner_d       = pick;
                    cur_ep_d      = ep_arr[pick];
                    rr_ptr_d      = (pick == RW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                end
            end
            XFER: begin
                if (own_done || !cur_free || !own_req || wd_fire) begin
                    state_d = RELEASE;
                    grant_d = '0;
                end
            end
            RELEASE: state_d = IDLE;
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        in_ep_data_put_o  = '0;
        in_ep_data_done_o = '0;
        in_ep_data_o      = '0;
        if (state_q == XFER) begin
            in_ep_data_o                = own_data;
            in_ep_data_put_o[cur_ep_q]  = own_put && cur_free;
            in_ep_data_done_o[cur_ep_q] = own_done || wd_fire;
        end
    end

endmodule

// File: tb/tb_usb_fs_in_arb.sv
// Scoreboard bench for usb_fs_in_arb: a round-robin reference model predicts grants,
// stimulus pushes expected PE events, a negedge monitor pops and compares them.
module tb_usb_fs_in_arb;

   localparam int NR = 4;
   localparam int NE = 11;

   typedef struct {
      bit         isDone;
      int         ep;
      logic [7:0] data;
   } evt_t;

   logic            clk = 1'b0;
   logic            reset;
   logic [NR-1:0]   req, reqPut, reqDone;
   logic [4*NR-1:0] reqEp;
   logic [8*NR-1:0] reqData;
   logic [NR-1:0]   grant, reqFree, reqAcked;
   logic [NE-1:0]   epPut, epDone, epFree, epAcked;
   logic [7:0]      epData;

   logic [NE-1:0]   blocked;
   logic [NE-1:0]   drainMask;
   int              epCount [NE];
   int              cycle = 0;

   evt_t            expQ [$];
   int              nCompared = 0;
   int              nMismatched = 0;

   int              rrModel = 0;
   bit              modelReq [NR];
   int              clientEp [NR];
   int              expGrantCycle = 0;

   usb_fs_in_arb dut (
      .clk               (clk),
      .reset             (reset),
      .req_i             (req),
      .req_ep_i          (reqEp),
      .req_put_i         (reqPut),
      .req_data_i        (reqData),
      .req_done_i        (reqDone),
      .grant_o           (grant),
      .req_free_o        (reqFree),
      .req_acked_o       (reqAcked),
      .in_ep_data_put_o  (epPut),
      .in_ep_data_o      (epData),
      .in_ep_data_done_o (epDone),
      .in_ep_data_free_i (epFree),
      .in_ep_acked_i     (epAcked)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Minimal PE: each endpoint buffers up to 32 bytes, empties on done or on a drain request.
   always @(posedge clk) begin
      for (int e = 0; e < NE; e++) begin
         if (drainMask[e] || epDone[e]) epCount[e] <= 0;
         else if (epPut[e])             epCount[e] <= epCount[e] + 1;
      end
   end

   always_comb begin
      epFree = '0;
      for (int e = 0; e < NE; e++) epFree[e] = !blocked[e] && (epCount[e] < 32);
   end

   function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cycle);
      end
   endfunction

   function automatic void pushExp(input bit isDone, input int ep, input logic [7:0] d);
      evt_t e;
      e.isDone = isDone;
      e.ep     = ep;
      e.data   = d;
      expQ.push_back(e);
   endfunction

   function automatic void observe(input bit isDone, input logic [NE-1:0] vec, input logic [7:0] d);
      evt_t e;
      if (expQ.size() == 0) begin
         checkOutput(isDone ? "unexpectedDone" : "unexpectedPut", 32'(vec), 0);
         return;
      end
      e = expQ.pop_front();
      checkOutput("eventKind", 32'(isDone), 32'(e.isDone));
      checkOutput(isDone ? "doneEp" : "putEp", 32'(vec), 32'(1) << e.ep);
      if (!isDone) checkOutput("putData", 32'(d), 32'(e.data));
   endfunction

   // Monitor: every cycle the PE sees a put or done, match it against the expected stream.
   always @(negedge clk) begin
      if (reset === 1'b0 && (|epPut || |epDone)) begin
         checkOutput("putOnehot", 32'($onehot0(epPut)), 1);
         checkOutput("doneOnehot", 32'($onehot0(epDone)), 1);
         if (|epPut)  observe(1'b0, epPut, epData);
         if (|epDone) observe(1'b1, epDone, 8'h00);
      end
   end

   // Round-robin reference: first requester, searching upward from the pointer, whose endpoint is usable.
   function automatic int pickNext();
      int idx;
      for (int j = 0; j < NR; j++) begin
         idx = (rrModel + j) % NR;
         if (modelReq[idx] && clientEp[idx] < NE && !blocked[clientEp[idx]]) return idx;
      end
      return -1;
   endfunction

   task automatic setReq(input int k, input int ep);
      req[k]          = 1'b1;
      reqEp[4*k +: 4] = 4'(ep);
      modelReq[k]     = 1'b1;
      clientEp[k]     = ep;
   endtask

   task automatic dropReq(input int k);
      req[k]      = 1'b0;
      reqPut[k]   = 1'b0;
      reqDone[k]  = 1'b0;
      modelReq[k] = 1'b0;
   endtask

   task automatic waitGrant(input int k, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         if (grant != '0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checkOutput("grantTimeout", 0, 32'(1) << k);
      end else begin
         checkOutput("grantWho", 32'(grant), 32'(1) << k);
         checkOutput("grantLatency", cycle, expGrantCycle);
         checkOutput("reqFree", 32'(reqFree), 32'(1) << k);
      end
   endtask

   // Serve client k once granted. mode 0: bytes + done, 1: bytes then drop req, 2: overfill without done.
   task automatic applyStimulus(input int k, input int nBytes, input int mode, input int holdCycles);
      bit         ok;
      bit         doneSent;
      int         ep;
      int         exitCycle;
      logic [7:0] b;
      ep        = clientEp[k];
      doneSent  = 1'b0;
      exitCycle = 0;
      waitGrant(k, ok);
      if (!ok) begin
         @(posedge clk); #1;
         dropReq(k);
         return;
      end
      rrModel = (k + 1) % NR;
      if (holdCycles > 0) begin
         repeat (holdCycles) @(negedge clk);
         checkOutput("grantHeld", 32'(grant), 32'(1) << k);
      end
      for (int i = 0; i < nBytes; i++) begin
         if (mode != 2 && $urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
            reqPut[k] = 1'b0;
         end
         @(posedge clk); #1;
         b                 = 8'($urandom);
         reqPut[k]         = 1'b1;
         reqData[8*k +: 8] = b;
         if (i >= 32) begin
            exitCycle = cycle;
            break;
         end
         pushExp(1'b0, ep, b);
         if (mode == 0 && i == nBytes - 1 && $urandom_range(0, 1) == 1) begin
            reqDone[k] = 1'b1;
            pushExp(1'b1, ep, 8'h00);
            doneSent  = 1'b1;
            exitCycle = cycle;
         end
      end
      if (mode == 0 && !doneSent) begin
         @(posedge clk); #1;
         reqPut[k]  = 1'b0;
         reqDone[k] = 1'b1;
         pushExp(1'b1, ep, 8'h00);
         exitCycle = cycle;
      end
      if (mode == 1) begin
         @(posedge clk); #1;
         dropReq(k);
         exitCycle = cycle;
      end
      @(posedge clk); #1;
      dropReq(k);
      drainMask[ep] = 1'b1;
      @(negedge clk);
      checkOutput("grantReleased", 32'(grant), 0);
      @(posedge clk); #1;
      drainMask     = '0;
      expGrantCycle = exitCycle + 3;
   endtask

   task automatic serveAll(input int maxLen, input bit allowAbort);
      int k;
      int modes [NR];
      int lens  [NR];
      for (int c = 0; c < NR; c++) begin
         modes[c] = (allowAbort && $urandom_range(0, 4) == 0) ? 1 : 0;
         lens[c]  = $urandom_range(0, maxLen);
      end
      k = pickNext();
      while (k >= 0) begin
         applyStimulus(k, lens[k], modes[k], 0);
         k = pickNext();
      end
   endtask

   initial begin
      #600000;
      $display("[TB] FAIL globalTimeout: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit         ok;
      bit         taken [NE];
      bit         a;
      int         ep;
      logic [7:0] b;

      reset     = 1'b1;
      req       = '0;
      reqPut    = '0;
      reqDone   = '0;
      reqEp     = '0;
      reqData   = '0;
      epAcked   = '0;
      blocked   = '0;
      drainMask = '0;
      for (int c = 0; c < NR; c++) begin
         modelReq[c] = 1'b0;
         clientEp[c] = 0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("resetGrant", 32'(grant), 0);
      checkOutput("resetPut", 32'(epPut), 0);
      checkOutput("resetDone", 32'(epDone), 0);
      checkOutput("resetData", 32'(epData), 0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Single client, three bytes and done.
      @(posedge clk); #1;
      setReq(0, 1);
      expGrantCycle = cycle + 1;
      applyStimulus(0, 3, 0, 0);

      // All clients at once, two passes, pointer wraps.
      for (int pass = 0; pass < 2; pass++) begin
         @(posedge clk); #1;
         for (int c = 0; c < NR; c++) setReq(c, c + 1);
         expGrantCycle = cycle + 1;
         serveAll(1, 1'b0);
      end

      // Overfill: 33rd byte is dropped and the port is released with no done.
      @(posedge clk); #1;
      setReq(1, 2);
      expGrantCycle = cycle + 1;
      applyStimulus(1, 33, 2, 0);

      // Blocked endpoint waits, out-of-range endpoint is never granted.
      @(posedge clk); #1;
      blocked[3] = 1'b1;
      setReq(0, 3);
      setReq(2, 4);
      setReq(1, 12);
      expGrantCycle = cycle + 1;
      checkOutput("pickFree", pickNext(), 2);
      applyStimulus(2, 2, 0, 0);
      repeat (4) begin
         @(negedge clk);
         checkOutput("noGrantWhileBlocked", 32'(grant), 0);
      end
      @(posedge clk); #1;
      blocked[3]    = 1'b0;
      expGrantCycle = cycle + 1;
      applyStimulus(0, 2, 0, 0);
      repeat (4) begin
         @(negedge clk);
         checkOutput("noGrantBadEp", 32'(grant), 0);
      end
      @(posedge clk); #1;
      dropReq(1);

`ifndef USB_IN_ARB_TIMEOUT_EN
      // Without the watchdog a silent owner keeps the port.
      @(posedge clk); #1;
      setReq(0, 5);
      expGrantCycle = cycle + 1;
      applyStimulus(0, 0, 1, 300);
`endif

      // Reset during a transfer.
      @(posedge clk); #1;
      setReq(1, 6);
      expGrantCycle = cycle + 1;
      waitGrant(1, ok);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         b                 = 8'($urandom);
         reqPut[1]         = 1'b1;
         reqData[8*1 +: 8] = b;
         if (ok) pushExp(1'b0, 6, b);
      end
      @(posedge clk); #1;
      reset     = 1'b1;
      reqPut[1] = 1'b0;
      @(posedge clk); #1;
      reset     = 1'b0;
      req[1]    = 1'b0;
      reqPut[1] = 1'b1;
      modelReq[1] = 1'b0;
      rrModel   = 0;
      @(negedge clk);
      checkOutput("grantAfterReset", 32'(grant), 0);
      checkOutput("putAfterReset", 32'(epPut), 0);
      @(posedge clk); #1;
      reqPut[1]    = 1'b0;
      drainMask[6] = 1'b1;
      @(posedge clk); #1;
      drainMask = '0;
      setReq(2, 7);
      setReq(0, 8);
      expGrantCycle = cycle + 1;
      checkOutput("pickAfterReset", pickNext(), 0);
      serveAll(2, 1'b0);

      // Randomised rounds.
      for (int r = 0; r < 20; r++) begin
         @(posedge clk); #1;
         for (int e = 0; e < NE; e++) taken[e] = 1'b0;
         for (int c = 0; c < NR; c++) begin
            if ($urandom_range(0, 9) < 7) begin
               if ($urandom_range(0, 9) == 0) begin
                  ep = $urandom_range(NE, 15);
               end else begin
                  ep = $urandom_range(0, NE - 1);
                  while (taken[ep]) ep = (ep + 1) % NE;
                  taken[ep] = 1'b1;
               end
               setReq(c, ep);
            end
         end
         epAcked       = NE'($urandom);
         expGrantCycle = cycle + 1;
         #1;
         for (int c = 0; c < NR; c++) begin
            a = 1'b0;
            if (clientEp[c] < NE) a = epAcked[clientEp[c]];
            checkOutput("reqAcked", 32'(reqAcked[c]), 32'(a));
         end
         serveAll(6, 1'b1);
         repeat (3) begin
            @(negedge clk);
            checkOutput("noGrantLeftover", 32'(grant), 0);
         end
         @(posedge clk); #1;
         for (int c = 0; c < NR; c++) dropReq(c);
      end

      repeat (3) @(negedge clk);
      checkOutput("queueEmpty", expQ.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
